// File: rtl/instr_fetch_responder.sv
`default_nettype none
// =============================================================================
// Module   : instr_fetch_responder
// Brief    : Wait-stated instruction fetch responder over a loadable 16-bit RAM.
// Revision : 1.0 - initial release
// =============================================================================
module instr_fetch_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int AW          = 5
) (
  input  logic          clock,
  input  logic          resetnot,
  input  logic          req,
  input  logic [AW-1:0] addr,
  output logic [15:0]   rdata,
  output logic          ack,
  output logic          busy,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [15:0]   load_data,
  output logic          err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] c_wait_init = 4'(WAIT_CYCLES);

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_addr;
  logic [15:0]   r_mem [2**AW];

  logic w_load_ok;
  logic w_accept;

  // A load in IDLE takes priority over a concurrent request.
  assign w_load_ok = (r_state == S_IDLE) && load_en;
  assign w_accept  = (r_state == S_IDLE) && req && !load_en;

  // Program memory deliberately has no reset so contents survive resetnot.
  always_ff @(posedge clock) begin
    if (w_load_ok) begin
      r_mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clock or negedge resetnot) begin
    if (!resetnot) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      rdata   <= 16'h0000;
      ack     <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr <= addr;
            r_cnt  <= c_wait_init;
            busy   <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              r_state <= S_RESP;
              rdata   <= r_mem[addr];
              ack     <= 1'b1;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          err <= load_en;
          if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
            rdata   <= r_mem[r_addr];
            ack     <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          err     <= load_en;
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
